// File: rtl/cpu_pkg.sv
// Encodings and defaults shared by the instruction sequencer and simple_cpu's CU.
package cpu_pkg;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam int unsigned DEF_STD_CYCLES   = 3;
  localparam int unsigned DEF_LOAD_CYCLES  = 4;
  localparam int unsigned DEF_STORE_CYCLES = 3;
  localparam int unsigned DEF_BOOT_CYCLES  = 1;

  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOOT,
    ST_FETCH,
    ST_HOLD,
    ST_DONE
  } seq_state_t;

  // Cycle totals include the FETCH cycle, so HOLD itself runs one cycle fewer.
  function automatic logic [HOLD_CNT_W-1:0] hold_load(
    input logic [1:0]  cls,
    input int unsigned std_c,
    input int unsigned load_c,
    input int unsigned store_c
  );
    int unsigned n;
    case (cls)
      CLS_STD:   n = std_c;
      CLS_LOAD:  n = load_c;
      CLS_STORE: n = store_c;
      default:   n = 1;
    endcase
    return (n > 1) ? HOLD_CNT_W'(n - 1) : HOLD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: synchronous write, asynchronous read, no reset.
module prog_mem #(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps a loaded program into simple_cpu, holding each word for its class's cycle count.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH  = 20,
  parameter int unsigned PC_BITS      = 4,
  parameter int unsigned STD_CYCLES   = DEF_STD_CYCLES,
  parameter int unsigned LOAD_CYCLES  = DEF_LOAD_CYCLES,
  parameter int unsigned STORE_CYCLES = DEF_STORE_CYCLES,
  parameter int unsigned BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   pause,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             instr_count
);

  seq_state_t             state;
  logic [HOLD_CNT_W-1:0]  hold_cnt;
  logic [PC_BITS-1:0]     next_pc;
  logic [PC_BITS-1:0]     rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [1:0]             cur_cls;
  logic [1:0]             fetch_cls;
  logic                   mem_we;

  always_comb begin
    next_pc   = pc + 1'b1;
    rd_addr   = (state == ST_FETCH) ? next_pc : '0;
    cur_cls   = instruction[INSTR_WIDTH-1 -: 2];
    fetch_cls = rd_data[INSTR_WIDTH-1 -: 2];
    mem_we    = prog_we && !start && (state == ST_IDLE || state == ST_DONE);
  end

  prog_mem #(
    .WIDTH     (INSTR_WIDTH),
    .ADDR_BITS (PC_BITS)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      instruction <= '0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instr_count <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_BOOT;
            pc          <= '0;
            instruction <= rd_data;
            instr_count <= '0;
            hold_cnt    <= HOLD_CNT_W'(BOOT_CYCLES);
            busy        <= 1'b1;
            done        <= 1'b0;
          end else if (state == ST_IDLE) begin
            instruction <= '0;
          end
        end
        ST_BOOT: if (!pause) begin
          if (hold_cnt <= 1) begin
            if (cur_cls == CLS_HALT) begin
              state       <= ST_DONE;
              instruction <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              state    <= ST_HOLD;
              hold_cnt <= hold_load(cur_cls, STD_CYCLES, LOAD_CYCLES, STORE_CYCLES);
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_HOLD: if (!pause) begin
          if (hold_cnt <= 1) begin
            if (instr_count != 8'hFF) instr_count <= instr_count + 1'b1;
            state <= ST_FETCH;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_FETCH: if (!pause) begin
          // End of memory and a halt word both stop here; pc keeps the last executed address.
          if (pc == '1 || fetch_cls == CLS_HALT) begin
            state       <= ST_DONE;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            state       <= ST_HOLD;
            pc          <= next_pc;
            instruction <= rd_data;
            hold_cnt    <= hold_load(fetch_cls, STD_CYCLES, LOAD_CYCLES, STORE_CYCLES);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
